frame_scanout: RTL
==================

Name: frame_scanout

Overview:
- Sits directly downstream of the Painter stage and consumes its framebuffer write port (we/addr/data) and its swapBuffers request.
- Owns two 32768x3 framebuffer banks. Painter writes always go to the back bank; the front bank is scanned out to a 640x480 VGA display.
- Each 160x120 logical pixel is replicated 4x4 on screen.
- Buffer swaps are deferred to the start of vertical blank, so the displayed frame never tears.

Parameters:
- CLK_DIV, 2: system clocks per VGA pixel (pixEn asserts once every CLK_DIV clocks).
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- SCALE_SHIFT, 2: screen-to-framebuffer coordinate shift (4x replication).

Ports:
- clk, input, 1: system clock; single clock domain.
- reset, input, 1: synchronous, active-high reset.
- we, input, 1: write enable from Painter.
- addr, input, 15: write address {y[6:0], x[7:0]}.
- data, input, 3: write colour {R,G,B}.
- swapBuffers, input, 1: swap request from Painter (one-cycle pulse or level).
- swapAck, output, 1: one-cycle pulse when a swap takes effect.
- frontSel, output, 1: index of the bank currently displayed.
- hsync, output, 1: horizontal sync, active low.
- vsync, output, 1: vertical sync, active low.
- red, green, blue, output, 1 each: pixel colour, forced 0 during blanking.

Behaviour:
- Reset (synchronous): hCount=0, vCount=0, pixEn divider=0, frontSel=0, swapPending=0, swapAck=0, hsync=1, vsync=1, RGB=0. RAM contents are not cleared.
- pixEn: asserts for one clk every CLK_DIV clks; the first pixEn is the clk after reset deasserts.
- Counters advance only on pixEn.
  - hCount runs 0..799 and wraps to 0.
  - vCount increments when hCount wraps, runs 0..524, and wraps to 0.
- Active region: hCount<640 and vCount<480.
- hsync=0 for hCount in [656,751]. vsync=0 for vCount in [490,491].
- Read address = {vCount[8:2], hCount[9:2]}.
  - x covers 0..159 and y covers 0..119.
  - Framebuffer locations with x>=160 or y>=120 are writable but never displayed.
- Write path:
  - When we=1, data is written at addr into bank ~frontSel on that clk edge.
  - A write in the same clk as a swap uses the pre-swap frontSel, i.e. the old back bank.
- Read path:
  - Synchronous RAM read, 1 clk latency.
  - hsync, vsync and the active flag pass through a matching delay so all outputs stay aligned.
  - Output latency from counter state to pins is fixed at 2 clk.
  - The RAM read and write ports are independent; a read and write to different banks never conflict.
- Swap state machine, states IDLE and PENDING:
  - IDLE -> PENDING when swapBuffers=1.
  - Swap point: the clk where pixEn=1, hCount=0 and vCount=480 (first blank line).
  - At the swap point, if PENDING or swapBuffers=1: frontSel toggles, swapAck=1 for exactly that one clk, state returns to IDLE.
  - Further swapBuffers assertions while PENDING merge into the same request: one swap, one ack.
  - swapBuffers held high across a swap point re-arms PENDING on the following clk. Painter must drop the request on swapAck.
- Reset mid-frame clears PENDING and returns frontSel to 0 without issuing an ack.
- Writes are never blocked or back-pressured.

Test Plan:
- Reset: hold reset 2 clk, release. Required on release: hsync=vsync=1, RGB=0, frontSel=0, swapAck=0. First hsync low occurs (656*2)+2=1314 clk after the first pixEn.
- Timing: line period is 1600 clk and hsync low lasts 192 clk. Frame period is 840000 clk and vsync low lasts 3200 clk. RGB=0 whenever hCount>=640 or vCount>=480.
- Back-bank isolation: write addr=15'h0000, data=3'b101. Required: screen pixel (0,0) stays at old bank-0 content and frontSel=0.
- Swap: pulse swapBuffers 1 clk. Required at the next vCount=480, hCount=0: swapAck pulses 1 clk and frontSel=1. Next frame, first 4 pixels (8 clk) of lines 0..3 show RGB=101.
- Merge: three swapBuffers pulses before the swap point. Required: exactly one swapAck and one frontSel toggle. No second toggle in the following frame.
- Edge cases:
  - swapBuffers asserted exactly on the swap-point clk swaps that frame.
  - reset asserted while PENDING gives frontSel=0, no swapAck, and no swap at the next vblank.

Source files
------------

// File: rtl/frame_scanout_if.sv
// Painter-to-scanout link: framebuffer write port plus the buffer-swap handshake.
//   we          : write strobe, one write per clk
//   addr        : write address {y[6:0], x[7:0]}
//   data        : write colour {R,G,B}
//   swapBuffers : swap request from Painter (pulse or level)
//   swapAck     : one-cycle pulse from scanout when the swap takes effect
// master = Painter side, slave = scanout side.
interface frame_scanout_if;
    logic        we;
    logic [14:0] addr;
    logic [2:0]  data;
    logic        swapBuffers;
    logic        swapAck;

    modport master (output we, addr, data, swapBuffers, input swapAck);
    modport slave  (input we, addr, data, swapBuffers, output swapAck);
endinterface

// File: rtl/frame_scanout.sv
// Double-buffered 160x120x3 framebuffer with 640x480 VGA scan-out.
// Painter writes always land in the back bank; the front bank is displayed
// with every logical pixel replicated (1 << SCALE_SHIFT) times in x and y.
// A swap request is held until the first clock of vertical blank, so the
// visible frame never tears.
// Ports:
//   clk, reset         : single clock, synchronous active-high reset
//   bus (slave)        : we/addr/data write port, swapBuffers/swapAck handshake
//   frontSel           : bank currently displayed
//   hsync, vsync       : active-low syncs
//   red, green, blue   : pixel colour, 0 outside the active region
// Every output is registered; pins lag the raster counters by exactly 2 clk.
module frame_scanout #(
    parameter int CLK_DIV     = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2
) (
    input  logic           clk,
    input  logic           reset,
    frame_scanout_if.slave bus,
    output logic           frontSel,
    output logic           hsync,
    output logic           vsync,
    output logic           red,
    output logic           green,
    output logic           blue
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    logic [DIV_W-1:0] div_r;
    logic [9:0]       hcount_r;
    logic [9:0]       vcount_r;
    swap_state_t      state_r;

    logic [2:0]       bank0_r [0:32767];
    logic [2:0]       bank1_r [0:32767];
    logic [2:0]       rd0_r;
    logic [2:0]       rd1_r;

    // Stage-1 companions of the RAM read, so sync/active stay aligned with it.
    logic             hs1_r;
    logic             vs1_r;
    logic             act1_r;
    logic             sel1_r;

    logic             pixen_s;
    logic             active_s;
    logic             hs_s;
    logic             vs_s;
    logic             swap_point_s;
    logic [14:0]      raddr_s;
    logic [2:0]       pix_s;

    // Raster decode: pixel enable, sync windows, swap point and read address.
    always_comb begin
        pixen_s      = (div_r == DIV_ZERO);
        active_s     = (hcount_r < H_ACT) && (vcount_r < V_ACT);
        hs_s         = ~((hcount_r >= HS_FIRST) && (hcount_r <= HS_LAST));
        vs_s         = ~((vcount_r >= VS_FIRST) && (vcount_r <= VS_LAST));
        swap_point_s = pixen_s && (hcount_r == 10'd0) && (vcount_r == V_ACT);
        raddr_s      = {7'(vcount_r >> SCALE_SHIFT), 8'(hcount_r >> SCALE_SHIFT)};
    end

    // Pixel-clock divider; zero right after reset so the first clk out of reset is a pixEn.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= DIV_ZERO;
        end else if (div_r == DIV_LAST) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Horizontal and vertical raster counters, advanced on pixEn only.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else if (pixen_s) begin
            if (hcount_r == H_LAST) begin
                hcount_r <= 10'd0;
                if (vcount_r == V_LAST) begin
                    vcount_r <= 10'd0;
                end else begin
                    vcount_r <= vcount_r + 10'd1;
                end
            end else begin
                hcount_r <= hcount_r + 10'd1;
            end
        end
    end

    // Swap controller: holds a request until the first clk of vertical blank.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            frontSel    <= 1'b0;
            bus.swapAck <= 1'b0;
        end else begin
            bus.swapAck <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A request arriving on the swap-point clk itself swaps this frame.
                    if (swap_point_s && bus.swapBuffers) begin
                        frontSel    <= ~frontSel;
                        bus.swapAck <= 1'b1;
                        state_r     <= IDLE;
                    end else if (bus.swapBuffers) begin
                        state_r <= PENDING;
                    end
                end
                PENDING: begin
                    // Repeated requests while pending simply keep us here.
                    if (swap_point_s) begin
                        frontSel    <= ~frontSel;
                        bus.swapAck <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Bank 0: written while bank 1 is displayed, read every clk.
    always_ff @(posedge clk) begin
        if (bus.we && frontSel) begin
            bank0_r[bus.addr] <= bus.data;
        end
        rd0_r <= bank0_r[raddr_s];
    end

    // Bank 1: written while bank 0 is displayed, read every clk.
    always_ff @(posedge clk) begin
        if (bus.we && !frontSel) begin
            bank1_r[bus.addr] <= bus.data;
        end
        rd1_r <= bank1_r[raddr_s];
    end

    // Stage 1: delay sync, active flag and bank select alongside the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs1_r  <= 1'b1;
            vs1_r  <= 1'b1;
            act1_r <= 1'b0;
            sel1_r <= 1'b0;
        end else begin
            hs1_r  <= hs_s;
            vs1_r  <= vs_s;
            act1_r <= active_s;
            sel1_r <= frontSel;
        end
    end

    // Pick the bank that was front when the read was issued; black in blanking.
    always_comb begin
        if (!act1_r) begin
            pix_s = 3'b000;
        end else if (sel1_r) begin
            pix_s = rd1_r;
        end else begin
            pix_s = rd0_r;
        end
    end

    // Stage 2: registered pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync              <= 1'b1;
            vsync              <= 1'b1;
            {red, green, blue} <= 3'b000;
        end else begin
            hsync              <= hs1_r;
            vsync              <= vs1_r;
            {red, green, blue} <= pix_s;
        end
    end
endmodule
